// File: rtl/wide_arith_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// default limb geometry and the sequencer FSM state encoding.
package wide_arith_pkg;

    localparam int unsigned W_DEF     = 128;
    localparam int unsigned LIMBS_DEF = 4;
    localparam int unsigned N_DEF     = W_DEF * LIMBS_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : wide_arith_pkg

// File: rtl/wide_add_sequencer_cla.sv
// Purely combinational Kogge-Stone prefix-sum carry-lookahead adder.
// Cin is folded into bit 0's generate so the prefix tree yields every carry directly.
module Prefix_Sum_CLA_128bit #(
    parameter int unsigned W = 128
) (
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         Cin,
    output logic [W-1:0] Sum,
    output logic         Cout
);

    localparam int unsigned LVL = $clog2(W);

    logic [LVL:0][W-1:0] g;
    logic [LVL:0][W-1:0] p;
    logic [W-1:0]        hp;
    logic [W-1:0]        carry;

    always_comb begin
        hp      = X ^ Y;
        g       = '0;
        p       = '0;
        g[0]    = X & Y;
        p[0]    = hp;
        g[0][0] = (X[0] & Y[0]) | (hp[0] & Cin);
        for (int unsigned l = 0; l < LVL; l++) begin
            for (int unsigned i = 0; i < W; i++) begin
                if (i >= (32'd1 << l)) begin
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][i - (32'd1 << l)]);
                    p[l+1][i] = p[l][i] & p[l][i - (32'd1 << l)];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end
        // g[LVL][i] is the carry out of bit i, already including Cin
        carry = {g[LVL][W-2:0], Cin};
        Sum   = hp ^ carry;
        Cout  = g[LVL][W-1];
    end

endmodule : Prefix_Sum_CLA_128bit

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract controller: feeds LIMBS operand limbs LSB-first
// through one shared W-bit CLA core, carrying between passes.
module wide_add_sequencer
    import wide_arith_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned LIMBS = LIMBS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [W*LIMBS-1:0]   A,
    input  logic [W*LIMBS-1:0]   B,
    output logic                 busy,
    output logic                 done,
    output logic [W*LIMBS-1:0]   Sum,
    output logic                 Cout,
    output logic                 Ovf
);

    localparam int unsigned    N      = W * LIMBS;
    localparam int unsigned    KW     = $clog2(LIMBS);
    localparam logic [KW-1:0]  K_LAST = KW'(LIMBS - 1);

    state_t         state_q;
    logic [KW-1:0]  k_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   bx_q;
    logic [N-1:0]   sum_q;
    logic           c_q;
    logic           cout_q;
    logic           ovf_q;
    logic           done_q;

    logic [W-1:0]   x_d;
    logic [W-1:0]   y_d;
    logic [W-1:0]   s_d;
    logic           cout_d;
    logic           ovf_d;

    assign x_d = a_q[k_q*W +: W];
    assign y_d = bx_q[k_q*W +: W];

    Prefix_Sum_CLA_128bit #(
        .W (W)
    ) u_core (
        .X    (x_d),
        .Y    (y_d),
        .Cin  (c_q),
        .Sum  (s_d),
        .Cout (cout_d)
    );

    // Only meaningful on the MSB limb pass, where it is captured
    assign ovf_d = (a_q[N-1] ~^ bx_q[N-1]) & (s_d[W-1] ^ a_q[N-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            bx_q    <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        bx_q    <= sub ? ~B : B;
                        c_q     <= sub;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[k_q*W +: W] <= s_d;
                    c_q               <= cout_d;
                    if (k_q == K_LAST) begin
                        cout_q  <= cout_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        k_q     <= '0;
                        state_q <= IDLE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule : wide_add_sequencer

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (W=128, LIMBS=4): table of hand-computed
// vectors plus sequences for busy-start, back-to-back issue and mid-operation reset.
module tb_wide_add_sequencer;

    localparam int unsigned W     = 128;
    localparam int unsigned LIMBS = 4;
    localparam int unsigned N     = W * LIMBS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    always #5 clk = ~clk;

    wide_add_sequencer #(
        .W     (W),
        .LIMBS (LIMBS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    typedef struct {
        logic         s;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] sum;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive start for one cycle; returns #1 after the sampling edge with inputs scrambled.
    task automatic issue(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        start = 1'b1;
        sub   = s;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        sub   = ~s;
        A     = {16{$urandom()}};
        B     = {16{$urandom()}};
    endtask

    task automatic wait_done(input int first, output int cyc);
        cyc = first;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int cyc;
        int extra;

        vecs[0] = '{1'b0, {N{1'b1}}, N'(1), '0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, {{384{1'b0}}, {128{1'b1}}}, N'(1),
                    {{383{1'b0}}, 1'b1, {128{1'b0}}}, 1'b0, 1'b0};
        vecs[2] = '{1'b1, N'(5), N'(7), {{511{1'b1}}, 1'b0}, 1'b0, 1'b0};
        vecs[3] = '{1'b0, {1'b0, {511{1'b1}}}, N'(1), {1'b1, {511{1'b0}}}, 1'b0, 1'b1};
        vecs[4] = '{1'b1, N'(7), N'(5), N'(2), 1'b1, 1'b0};
        vecs[5] = '{1'b1, {1'b1, {511{1'b0}}}, N'(1), {1'b0, {511{1'b1}}}, 1'b1, 1'b1};
        vecs[6] = '{1'b1, N'(0), N'(0), N'(0), 1'b1, 1'b0};
        vecs[7] = '{1'b0, {{128{1'b0}}, {384{1'b1}}}, N'(1),
                    {{127{1'b0}}, 1'b1, {384{1'b0}}}, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", N'(busy), '0);
        check("reset.done", N'(done), '0);
        check("reset.sum",  Sum,      '0);
        check("reset.cout", N'(Cout), '0);
        check("reset.ovf",  N'(Ovf),  '0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            issue(vecs[v].s, vecs[v].a, vecs[v].b);
            check($sformatf("vec%0d.busy", v), N'(busy), N'(1));
            wait_done(0, cyc);
            check($sformatf("vec%0d.latency", v), N'(cyc), N'(4));
            check($sformatf("vec%0d.sum", v),  Sum,      vecs[v].sum);
            check($sformatf("vec%0d.cout", v), N'(Cout), N'(vecs[v].co));
            check($sformatf("vec%0d.ovf", v),  N'(Ovf),  N'(vecs[v].ov));
            check($sformatf("vec%0d.idle", v), N'(busy), '0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.pulse", v), N'(done), '0);
        end

        // start while busy must be ignored
        issue(1'b0, N'(1), N'(2));
        @(negedge clk);
        start = 1'b1;
        sub   = 1'b1;
        A     = N'(100);
        B     = N'(200);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, cyc);
        check("busy_start.latency", N'(cyc), N'(4));
        check("busy_start.sum",     Sum,      N'(3));
        check("busy_start.cout",    N'(Cout), '0);
        count_dones(8, extra);
        check("busy_start.no_extra_done", N'(extra), '0);

        // back-to-back: second start asserted in the done cycle
        issue(1'b0, N'(10), N'(20));
        wait_done(0, cyc);
        check("b2b.first.latency", N'(cyc), N'(4));
        check("b2b.first.sum",     Sum,      N'(30));
        start = 1'b1;
        sub   = 1'b1;
        A     = N'(50);
        B     = N'(8);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b.second.busy", N'(busy), N'(1));
        wait_done(0, cyc);
        check("b2b.second.latency", N'(cyc), N'(4));
        check("b2b.second.sum",     Sum,      N'(42));
        check("b2b.second.cout",    N'(Cout), N'(1));
        check("b2b.second.ovf",     N'(Ovf),  '0);

        // leave Cout=1, Ovf=1 and a nonzero Sum, then reset mid-operation at k=2
        issue(vecs[5].s, vecs[5].a, vecs[5].b);
        wait_done(0, cyc);
        check("prereset.ovf", N'(Ovf), N'(1));
        issue(1'b0, {N{1'b1}}, N'(1));
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.busy", N'(busy), '0);
        check("midrst.done", N'(done), '0);
        check("midrst.sum",  Sum,      '0);
        check("midrst.cout", N'(Cout), '0);
        check("midrst.ovf",  N'(Ovf),  '0);
        @(negedge clk);
        rst = 1'b0;
        count_dones(8, extra);
        check("midrst.no_done", N'(extra), '0);
        issue(vecs[1].s, vecs[1].a, vecs[1].b);
        wait_done(0, cyc);
        check("postrst.latency", N'(cyc), N'(4));
        check("postrst.sum",     Sum,      vecs[1].sum);
        check("postrst.cout",    N'(Cout), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wide_add_sequencer
